acc_cpu_ctrl: RTL and testbench

Multi-cycle control unit that sequences the 16-bit accumulator datapath: the accumulator register, ALU, PC, IR and memory port. It runs a fetch/decode/execute FSM and issues accce, ALU function, PC/IR enables and memory requests. It consumes the accumulator status flags acc15 and accz for conditional jumps. Memory is variable-latency through a req/ack handshake.

---
 rtl/acc_cpu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_acc_cpu_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/acc_cpu_ctrl.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine; strobes are decoded from state.
// Latency: fetch 1 + decode 1 cycle, memory ops +1 cycle; each memory wait cycle adds 1 cycle.
// Backpressure: mem_req and its address/direction hold until mem_ack; reset drops them at once.
module acc_cpu_ctrl #(
  parameter int ALUFS_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         opcode,
  input  logic               acc15,
  input  logic               accz,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               irce,
  output logic               pcce,
  output logic               pc_sel,
  output logic               accce,
  output logic [ALUFS_W-1:0] alufs,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_MEMWR  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;

  localparam logic [ALUFS_W-1:0] FS_PASSB = ALUFS_W'(4'h0);
  localparam logic [ALUFS_W-1:0] FS_ADD   = ALUFS_W'(4'h1);
  localparam logic [ALUFS_W-1:0] FS_SUB   = ALUFS_W'(4'h2);
  localparam logic [ALUFS_W-1:0] FS_AND   = ALUFS_W'(4'h3);
  localparam logic [ALUFS_W-1:0] FS_OR    = ALUFS_W'(4'h4);
  localparam logic [ALUFS_W-1:0] FS_NOTA  = ALUFS_W'(4'h5);
  localparam logic [ALUFS_W-1:0] FS_PASSA = ALUFS_W'(4'hF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [ALUFS_W-1:0] rd_fs;

  // ALU function for memory-operand instructions, held for the whole MEMRD state
  always_comb begin
    rd_fs = FS_PASSA;
    case (opcode)
      OP_LDA:  rd_fs = FS_PASSB;
      OP_ADD:  rd_fs = FS_ADD;
      OP_SUB:  rd_fs = FS_SUB;
      OP_AND:  rd_fs = FS_AND;
      OP_OR:   rd_fs = FS_OR;
      default: rd_fs = FS_PASSA;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    irce     = 1'b0;
    pcce     = 1'b0;
    pc_sel   = 1'b0;
    accce    = 1'b0;
    alufs    = FS_PASSA;
    halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          irce    = 1'b1;
          pcce    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            state_d = S_MEMRD;
            retire  = 1'b0;
          end
          OP_STA: begin
            state_d = S_MEMWR;
            retire  = 1'b0;
          end
          OP_JMP: begin
            pcce   = 1'b1;
            pc_sel = 1'b1;
          end
          OP_JGE: begin
            pcce   = ~acc15;
            pc_sel = ~acc15;
          end
          OP_JNE: begin
            pcce   = ~accz;
            pc_sel = ~accz;
          end
          OP_NOT: begin
            accce = 1'b1;
            alufs = FS_NOTA;
          end
          OP_STP:  state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        alufs    = rd_fs;
        if (mem_ack) begin
          accce   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    // Reset silences every output in the same cycle so a pending write is never issued
    if (!rst_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      irce     = 1'b0;
      pcce     = 1'b0;
      pc_sel   = 1'b0;
      accce    = 1'b0;
      alufs    = FS_PASSA;
      halted   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Directed bench for acc_cpu_ctrl: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_acc_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        acc15 = 1'b0;
  logic        accz = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, addr_sel, irce, pcce, pc_sel, accce, halted;
  logic [3:0]  alufs;
  logic [15:0] instr_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_cpu_ctrl #(.ALUFS_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .acc15     (acc15),
    .accz      (accz),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .irce      (irce),
    .pcce      (pcce),
    .pc_sel    (pc_sel),
    .accce     (accce),
    .alufs     (alufs),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  // {mem_req, mem_we, addr_sel, irce, pcce, pc_sel, accce, halted, alufs}
  logic [11:0] outv;
  assign outv = {mem_req, mem_we, addr_sel, irce, pcce, pc_sel, accce, halted, alufs};

  function automatic logic [11:0] ov(input logic req, we, as, ir, pc, ps, ac, h,
                                     input logic [3:0] fs);
    return {req, we, as, ir, pc, ps, ac, h, fs};
  endfunction

  localparam logic [11:0] IDLE    = 12'b0000_0000_1111;
  localparam logic [11:0] FETCH_W = 12'b1000_0000_1111;
  localparam logic [11:0] FETCH_A = 12'b1001_1000_1111;
  localparam logic [11:0] HALTV   = 12'b0000_0001_1111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] opc,
                      input logic a15, input logic az, input logic ack,
                      input logic [11:0] exp);
    @(negedge clk);
    rst_n = rst; opcode = opc; acc15 = a15; accz = az; mem_ack = ack;
    #1;
    chk(tag, {20'd0, outv}, {20'd0, exp});
  endtask

  task automatic cnt_is(input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    chk(tag, {16'd0, instr_cnt}, {16'd0, exp});
  endtask

  initial begin
    // Reset: everything quiet even with a stray ack
    step("rst_out0", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, IDLE);
    step("rst_out1", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, IDLE);
    cnt_is("rst_cnt", 16'd0);

    // LDA, ADD, STA with zero-wait memory
    step("lda_fetch",  1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("lda_decode", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, IDLE);
    step("lda_memrd",  1'b1, 4'h0, 1'b0, 1'b0, 1'b1, ov(1,0,1,0,0,0,1,0,4'h0));
    cnt_is("lda_cnt", 16'd1);
    step("add_fetch",  1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("add_decode", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, IDLE);
    step("add_memrd",  1'b1, 4'h2, 1'b0, 1'b0, 1'b1, ov(1,0,1,0,0,0,1,0,4'h1));
    step("sta_fetch",  1'b1, 4'h2, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("sta_decode", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, IDLE);
    step("sta_memwr",  1'b1, 4'h1, 1'b0, 1'b0, 1'b1, ov(1,1,1,0,0,0,0,0,4'hF));
    cnt_is("prog_cnt", 16'd3);

    // Fetch with three wait cycles, then JGE falling through on acc15=1
    step("wait_f0", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, FETCH_W);
    step("wait_f1", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, FETCH_W);
    step("wait_f2", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, FETCH_W);
    step("wait_ack", 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("jge_neg",  1'b1, 4'h5, 1'b1, 1'b0, 1'b0, IDLE);
    step("jge_pos_f", 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("jge_pos",   1'b1, 4'h5, 1'b0, 1'b0, 1'b0, ov(0,0,0,0,1,1,0,0,4'hF));
    step("jne_z_f",  1'b1, 4'h5, 1'b0, 1'b1, 1'b1, FETCH_A);
    step("jne_z",    1'b1, 4'h6, 1'b0, 1'b1, 1'b0, IDLE);
    step("jne_nz_f", 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("jne_nz",   1'b1, 4'h6, 1'b1, 1'b0, 1'b0, ov(0,0,0,0,1,1,0,0,4'hF));
    step("jmp_f",    1'b1, 4'h6, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("jmp",      1'b1, 4'h4, 1'b1, 1'b1, 1'b0, ov(0,0,0,0,1,1,0,0,4'hF));
    cnt_is("jump_cnt", 16'd8);

    // NOT and undefined opcode; ack in DECODE must be ignored
    step("not_f",    1'b1, 4'h4, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("not",      1'b1, 4'hA, 1'b0, 1'b0, 1'b0, ov(0,0,0,0,0,0,1,0,4'h5));
    step("nop_f",    1'b1, 4'hA, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("nop_e",    1'b1, 4'hE, 1'b0, 1'b0, 1'b1, IDLE);
    cnt_is("nop_cnt", 16'd10);

    // Reset while a write is outstanding
    step("rw_f",      1'b1, 4'hE, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("rw_decode", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, IDLE);
    step("rw_wait",   1'b1, 4'h1, 1'b0, 1'b0, 1'b0, ov(1,1,1,0,0,0,0,0,4'hF));
    step("rw_abort",  1'b0, 4'h1, 1'b0, 1'b0, 1'b0, IDLE);
    cnt_is("rw_cnt", 16'd0);
    step("rw_restart", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, FETCH_W);

    // STP then 20 halted cycles with ack noise
    step("stp_f", 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, FETCH_A);
    step("stp",   1'b1, 4'h7, 1'b0, 1'b0, 1'b0, IDLE);
    cnt_is("stp_cnt", 16'd1);
    for (int i = 0; i < 20; i++) begin
      step("halt", 1'b1, 4'h7, 1'b0, 1'b0, 1'(i % 2), HALTV);
    end
    cnt_is("halt_cnt", 16'd1);
    step("halt_rst", 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, IDLE);
    cnt_is("halt_rst_cnt", 16'd0);
    step("halt_exit", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, FETCH_W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
